// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the 8-digit 7-segment scan driver.
// Contents:
//   ADDR_DATA / ADDR_CTRL : register select values on the CPU addr line
//   CTRL_RESET            : CTRL value out of reset (all digits on, no dp)
//   HEX7_TABLE            : nibble -> active-high segments {g,f,e,d,c,b,a}
package seg7_scan_driver_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam logic [15:0] CTRL_RESET = 16'h00FF;

  // Element 15 is listed first so that HEX7_TABLE[n] is the glyph for n.
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// CPU register bus for the scan driver (same bus as the LED register).
// Signals:
//   we   : write enable, single-cycle, always accepted
//   addr : 0 = DATA, 1 = CTRL
//   wd   : write data
//   rd   : combinational readback
// Modports: master = CPU side, slave = display peripheral side.
interface seg7_scan_driver_if;
  logic        we;
  logic        addr;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, output addr, output wd, input rd);
  modport slave  (input we, input addr, input wd, output rd);
endinterface

// File: rtl/seg7_scan_driver_hex_decode.sv
// Combinational hex digit decoder.
// Ports:
//   nibble : 4-bit value to display
//   segs   : active-high segments {g,f,e,d,c,b,a}
module seg7_hex_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  always_comb begin
    segs = HEX7_TABLE[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed 7-segment driver fed from a CPU-mapped DATA register.
// The value is copied into a shadow register once per frame so a digit never
// shows a half-updated word. Each digit slot starts with a short blank window
// to stop ghosting while the digit enables switch.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : CPU register bus (slave side)
//   digit_sel  : digit enables, active-low, bit i = digit i (0 = rightmost)
//   seg        : segments {dp,g,f,e,d,c,b,a}, active-low
//   frame_tick : one-cycle pulse after the shadow register loads
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter int PRESC_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_driver_if.slave   bus,
  output logic [7:0]          digit_sel,
  output logic [7:0]          seg,
  output logic                frame_tick
);

  logic [31:0]        data_reg;
  logic [15:0]        ctrl_reg;
  logic [31:0]        shadow;
  logic [PRESC_W-1:0] presc;
  logic [2:0]         idx;
  logic               presc_wrap;
  logic               frame_wrap;
  logic [3:0]         nibble;
  logic [6:0]         hex_segs;
  logic [7:0]         next_sel;
  logic [7:0]         next_seg;

  assign presc_wrap = (presc == PRESC_W'(SCAN_DIV - 1));
  assign frame_wrap = presc_wrap && (idx == 3'd7);

  always_comb begin
    bus.rd = (bus.addr == ADDR_CTRL) ? {16'h0000, ctrl_reg} : data_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
      ctrl_reg <= CTRL_RESET;
    end else if (bus.we) begin
      if (bus.addr == ADDR_DATA) data_reg <= bus.wd;
      else                       ctrl_reg <= bus.wd[15:0];
    end
  end

  // The shadow samples data_reg before any write on the same edge lands,
  // so a write coinciding with the frame wrap shows up one frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      shadow     <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_wrap;
      if (presc_wrap) begin
        presc <= '0;
        idx   <= idx + 3'd1;
      end else begin
        presc <= presc + PRESC_W'(1);
      end
      if (frame_wrap) shadow <= data_reg;
    end
  end

  assign nibble = shadow[{idx, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .nibble (nibble),
    .segs   (hex_segs)
  );

  always_comb begin
    next_sel = 8'hFF;
    next_seg = 8'hFF;
    if (presc >= PRESC_W'(BLANK_CYCLES) && ctrl_reg[idx]) begin
      next_sel = ~(8'b1 << idx);
      next_seg = {~ctrl_reg[{1'b1, idx}], ~hex_segs};
    end
  end

  // Registering the pins keeps glitches from the decoder off the board.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel <= 8'hFF;
      seg       <= 8'hFF;
    end else begin
      digit_sel <= next_sel;
      seg       <= next_seg;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with a small scan configuration.
// A reference model tracks elapsed cycles since reset and derives the slot,
// digit and frame boundaries arithmetically, plus the DATA/CTRL/shadow values.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYCLES = 1;
  localparam int FRAME        = 8 * SCAN_DIV;

  logic       clk;
  logic       rst_n;
  logic [7:0] digit_sel;
  logic [7:0] seg;
  logic       frame_tick;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .PRESC_W      (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .digit_sel  (digit_sel),
    .seg        (seg),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  int          cyc;
  logic [31:0] m_data;
  logic [15:0] m_ctrl;
  logic [31:0] m_shadow;

  // Glyphs for 0..F, active-high {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic modelReset();
    cyc      = 0;
    m_data   = 32'h0;
    m_ctrl   = 16'h00FF;
    m_shadow = 32'h0;
  endtask

  // One clock cycle: drive bus inputs, predict pins from the pre-edge
  // position in the frame, advance the model, then check after the edge.
  task automatic applyStimulus(input logic we_i, input logic addr_i, input logic [31:0] wd_i);
    int          slot_pos;
    int          digit;
    logic [7:0]  exp_sel;
    logic [7:0]  exp_seg;
    logic        seg_defined;
    logic        exp_tick;
    bus.we   = we_i;
    bus.addr = addr_i;
    bus.wd   = wd_i;
    slot_pos = cyc % SCAN_DIV;
    digit    = (cyc / SCAN_DIV) % 8;
    exp_sel     = 8'hFF;
    exp_seg     = 8'hFF;
    seg_defined = 1'b1;
    if (slot_pos >= BLANK_CYCLES) begin
      if (m_ctrl[digit]) begin
        exp_sel = ~(8'd1 << digit);
        exp_seg = {~m_ctrl[8 + digit], ~glyph(m_shadow[4 * digit +: 4])};
      end else begin
        seg_defined = 1'b0;
      end
    end
    exp_tick = ((cyc % FRAME) == FRAME - 1);
    if (exp_tick) m_shadow = m_data;
    if (we_i) begin
      if (addr_i == 1'b0) m_data = wd_i;
      else                m_ctrl = wd_i[15:0];
    end
    @(posedge clk);
    #1;
    cyc++;
    checkOutput("digit_sel", {24'h0, digit_sel}, {24'h0, exp_sel});
    if (seg_defined) checkOutput("seg", {24'h0, seg}, {24'h0, exp_seg});
    checkOutput("frame_tick", {31'h0, frame_tick}, {31'h0, exp_tick});
    bus.we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0);
  endtask

  // Advance until the next edge is the given position within the frame.
  task automatic runToPhase(input int ph);
    for (int i = 0; i < FRAME && (cyc % FRAME) != ph; i++) applyStimulus(1'b0, 1'b0, 32'h0);
  endtask

  task automatic checkReadback(input string tag);
    bus.we   = 1'b0;
    bus.addr = 1'b0;
    #1;
    checkOutput({tag, "_rd_data"}, bus.rd, m_data);
    bus.addr = 1'b1;
    #1;
    checkOutput({tag, "_rd_ctrl"}, bus.rd, {16'h0, m_ctrl});
  endtask

  initial begin
    bus.we   = 1'b0;
    bus.addr = 1'b0;
    bus.wd   = 32'h0;
    rst_n    = 1'b0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_digit_sel", {24'h0, digit_sel}, 32'hFF);
    checkOutput("reset_seg", {24'h0, seg}, 32'hFF);
    checkOutput("reset_frame_tick", {31'h0, frame_tick}, 32'h0);
    checkReadback("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] idle scan after reset");
    idle(40);

    $display("[TB] mid-frame DATA write");
    runToPhase(10);
    applyStimulus(1'b1, 1'b0, 32'h89AB_CDEF);
    idle(FRAME + 8);

    $display("[TB] DATA write on the frame wrap edge");
    runToPhase(FRAME - 1);
    applyStimulus(1'b1, 1'b0, $urandom);
    idle(2 * FRAME + 2);

    $display("[TB] CTRL write selecting digits 0 and 2");
    applyStimulus(1'b1, 1'b1, 32'hABCD_0105);
    idle(FRAME + 4);
    checkReadback("ctrl0105");

    $display("[TB] randomized bus traffic");
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0)
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom);
      else
        applyStimulus(1'b0, 1'b0, 32'h0);
    end
    checkReadback("random");

    $display("[TB] async reset during digit 5");
    applyStimulus(1'b1, 1'b1, 32'h0000_00FF);
    runToPhase(5 * SCAN_DIV + 2);
    rst_n = 1'b0;
    #1;
    checkOutput("async_digit_sel", {24'h0, digit_sel}, 32'hFF);
    checkOutput("async_seg", {24'h0, seg}, 32'hFF);
    checkOutput("async_frame_tick", {31'h0, frame_tick}, 32'h0);
    modelReset();
    checkReadback("async");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h1234_5678);
    idle(2 * FRAME + 4);
    checkReadback("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
